// File: rtl/wb_mailbox_pkg.sv
// Shared definitions for the Wishbone end-of-test / console mailbox.
// The TIMEOUT state exists only when WB_MAILBOX_TIMEOUT_EN is defined.
package wb_mailbox_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_TXDATA = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_CYCLES = 2'd3;

  localparam int ST_DONE    = 0;
  localparam int ST_PASS    = 1;
  localparam int ST_FULL    = 2;
  localparam int ST_EMPTY   = 3;
  localparam int ST_OVF     = 4;
  localparam int ST_TIMEOUT = 5;

  localparam logic [7:0] PASS_CODE = 8'h01;
  localparam logic [7:0] FAIL_CODE = 8'hFF;

`ifdef WB_MAILBOX_TIMEOUT_EN
  typedef enum logic [1:0] {S_RUN, S_DONE_PASS, S_DONE_FAIL, S_TIMEOUT} state_t;
`else
  typedef enum logic [1:0] {S_RUN, S_DONE_PASS, S_DONE_FAIL} state_t;
`endif

endpackage

// File: rtl/wb_mailbox_sync_fifo.sv
// Single-clock FIFO with a combinational head; a push into a full FIFO is
// accepted only when a pop frees a slot on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  assign count   = wr_ptr_reg - rd_ptr_reg;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/wb_mailbox.sv
// Wishbone classic mailbox: sticky pass/fail flags, TX byte FIFO, cycle counter.
// Optional run timeout enabled by defining WB_MAILBOX_TIMEOUT_EN.
module wb_mailbox
  import wb_mailbox_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int          FIFO_DEPTH = 16,
  parameter int unsigned MAX_CYCLES = 200_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  output logic        wb_ack_o,
  output logic [31:0] wb_dat_o,
  output logic        done_o,
  output logic        pass_o,
  output logic        timeout_o,
  output logic        rd_valid_o,
  output logic [7:0]  rd_data_o,
  input  logic        rd_ready_i
);

  if (BASE_ADDR[3:0] != 4'h0 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || MAX_CYCLES == 0) begin : g_bad_param
    $error("wb_mailbox: illegal parameter value");
  end

  state_t      state_reg, state_next;
  logic        ack_reg;
  logic [31:0] dat_reg;
  logic [31:0] cycles_reg;
  logic        ovf_reg;
  logic [31:0] rd_mux;

  logic        sel, commit, wr_commit, rd_commit;
  logic [1:0]  reg_idx;
  logic        ctrl_wr, tx_wr, ovf_clr, fifo_pop;
  logic        fifo_full, fifo_empty;
  logic [7:0]  fifo_head;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic        cnt_en;
  logic        unused_bits;

  assign unused_bits = ^{wb_adr_i[1:0], wb_dat_i[31:8], wb_sel_i[3:1]};

  // A transfer commits on the edge that raises ack; ack then blocks a repeat.
  assign sel       = wb_cyc_i & wb_stb_i & (wb_adr_i[31:4] == BASE_ADDR[31:4]);
  assign commit    = sel & ~ack_reg;
  assign wr_commit = commit & wb_we_i;
  assign rd_commit = commit & ~wb_we_i;
  assign reg_idx   = wb_adr_i[3:2];

  assign ctrl_wr  = wr_commit & wb_sel_i[0] & (reg_idx == REG_CTRL);
  assign tx_wr    = wr_commit & wb_sel_i[0] & (reg_idx == REG_TXDATA);
  assign ovf_clr  = wr_commit & wb_sel_i[0] & (reg_idx == REG_STATUS) & wb_dat_i[ST_OVF];
  assign fifo_pop = rd_ready_i & ~fifo_empty;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx_wr),
    .wdata (wb_dat_i[7:0]),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

`ifdef WB_MAILBOX_TIMEOUT_EN
  logic timeout_hit;
  assign timeout_hit = (state_reg == S_RUN) && (cycles_reg == 32'(MAX_CYCLES));
  assign cnt_en      = (state_reg == S_RUN) && (cycles_reg != '1) && !timeout_hit;
  assign timeout_o   = (state_reg == S_TIMEOUT);
`else
  assign cnt_en      = (state_reg == S_RUN) && (cycles_reg != '1);
  assign timeout_o   = 1'b0;
`endif

  // A pass/fail code committing on the timeout edge takes priority.
  always_comb begin
    state_next = state_reg;
    if (state_reg == S_RUN) begin
      if (ctrl_wr && wb_dat_i[7:0] == PASS_CODE)      state_next = S_DONE_PASS;
      else if (ctrl_wr && wb_dat_i[7:0] == FAIL_CODE) state_next = S_DONE_FAIL;
`ifdef WB_MAILBOX_TIMEOUT_EN
      else if (timeout_hit)                           state_next = S_TIMEOUT;
`endif
    end
  end

  assign done_o     = (state_reg != S_RUN);
  assign pass_o     = (state_reg == S_DONE_PASS);
  assign rd_valid_o = ~fifo_empty;
  assign rd_data_o  = fifo_empty ? 8'h00 : fifo_head;

  always_comb begin
    rd_mux = '0;
    case (reg_idx)
      REG_STATUS: begin
        rd_mux[ST_DONE]    = done_o;
        rd_mux[ST_PASS]    = pass_o;
        rd_mux[ST_FULL]    = fifo_full;
        rd_mux[ST_EMPTY]   = fifo_empty;
        rd_mux[ST_OVF]     = ovf_reg;
        rd_mux[ST_TIMEOUT] = timeout_o;
        rd_mux[15:8]       = 8'(fifo_count);
      end
      REG_CYCLES: rd_mux = cycles_reg;
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_RUN;
      ack_reg    <= 1'b0;
      dat_reg    <= '0;
      cycles_reg <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      ack_reg   <= commit;
      dat_reg   <= rd_commit ? rd_mux : '0;
      if (cnt_en) cycles_reg <= cycles_reg + 32'd1;
      if (tx_wr && fifo_full && !fifo_pop) ovf_reg <= 1'b1;
      else if (ovf_clr)                    ovf_reg <= 1'b0;
    end
  end

  assign wb_ack_o = ack_reg;
  assign wb_dat_o = dat_reg;

endmodule

// File: tb/tb_wb_mailbox.sv
// Randomised and directed bench for wb_mailbox against a queue-based model.
module tb_wb_mailbox;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 16;
  localparam int unsigned MAXC  = 100;
`ifdef WB_MAILBOX_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [31:0] adr = '0, wdat = '0;
  logic [3:0]  sel = '0;
  logic        ack, done, pass, tout, rd_valid, rd_ready = 1'b0;
  logic [31:0] rdat;
  logic [7:0]  rd_data;

  int checks = 0;
  int failures = 0;

  // Model: 0 run, 1 pass, 2 fail, 3 timeout
  int          m_state;
  bit          m_ovf;
  logic [7:0]  q[$];
  logic [31:0] m_cnt;
  bit          m_ack;
  logic [31:0] m_dat;

  wb_mailbox #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .MAX_CYCLES(MAXC)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
    .wb_ack_o(ack), .wb_dat_o(rdat),
    .done_o(done), .pass_o(pass), .timeout_o(tout),
    .rd_valid_o(rd_valid), .rd_data_o(rd_data), .rd_ready_i(rd_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_ovf = 0; q.delete(); m_cnt = 0; m_ack = 0; m_dat = 0;
  endtask

  task automatic check_all();
    check("ack", 32'(ack), 32'(m_ack));
    check("dat", rdat, m_dat);
    check("done", 32'(done), 32'(m_state != 0));
    check("pass", 32'(pass), 32'(m_state == 1));
    check("timeout", 32'(tout), 32'(m_state == 3));
    check("rd_valid", 32'(rd_valid), 32'(q.size() > 0));
    check("rd_data", 32'(rd_data), (q.size() > 0) ? 32'(q[0]) : 32'd0);
  endtask

  // One clock: predict from pre-edge inputs, advance, then compare.
  task automatic tick();
    bit hit, commit, popping, push, to_hit;
    logic [31:0] rv;
    int nstate;
    hit     = cyc && stb && (adr[31:4] == BASE[31:4]);
    commit  = hit && !m_ack;
    popping = rd_ready && (q.size() > 0);
    rv = 0;
    if (adr[3:2] == 2'd2)
      rv = {16'd0, 8'(q.size()), 2'b00, (m_state == 3), m_ovf, (q.size() == 0),
            (q.size() == DEPTH), (m_state == 1), (m_state != 0)};
    else if (adr[3:2] == 2'd3)
      rv = m_cnt;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      nstate = m_state;
      push = 0;
      if (m_state == 0) begin
        to_hit = TO_EN && (m_cnt == MAXC);
        if (to_hit) nstate = 3;
        if (commit && we && sel[0] && adr[3:2] == 2'd0) begin
          if (wdat[7:0] == 8'h01) nstate = 1;
          else if (wdat[7:0] == 8'hFF) nstate = 2;
        end
        if (!to_hit && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      end
      if (commit && we && sel[0] && adr[3:2] == 2'd1) begin
        if (q.size() < DEPTH || popping) push = 1;
        else m_ovf = 1;
      end
      if (commit && we && sel[0] && adr[3:2] == 2'd2 && wdat[4]) m_ovf = 0;
      if (popping) void'(q.pop_front());
      if (push) q.push_back(wdat[7:0]);
      m_dat   = (commit && !we) ? rv : 32'd0;
      m_ack   = commit;
      m_state = nstate;
    end
    #1;
    check_all();
  endtask

  task automatic bus(input logic [31:0] a, input bit w, input logic [31:0] d,
                     output logic [31:0] r);
    cyc = 1; stb = 1; adr = a; we = w; wdat = d; sel = 4'hF;
    tick();
    r = rdat;
    cyc = 0; stb = 0; we = 0;
    tick();
  endtask

  task automatic do_reset();
    cyc = 0; stb = 0; we = 0; rd_ready = 0;
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
  endtask

  logic [31:0] r;

  initial begin
    model_reset();
    tick(); tick();
    rst_n = 1;

    // Pass code
    bus(BASE + 32'h0, 1, 32'h01, r);
    check("pass_done", 32'(done), 32'd1);
    bus(BASE + 32'h8, 0, 0, r);
    check("status_pass", r, 32'h0000_000B);

    // Fail then pass: fail sticks
    do_reset();
    bus(BASE + 32'h0, 1, 32'hFF, r);
    bus(BASE + 32'h0, 1, 32'h01, r);
    check("fail_sticky", {30'd0, done, pass}, 32'h2);

    // Overflow with 17 writes
    do_reset();
    for (int i = 0; i < 17; i++) bus(BASE + 32'h4, 1, 32'h41 + i, r);
    bus(BASE + 32'h8, 0, 0, r);
    check("status_ovf", r, 32'h0000_1014);
    rd_ready = 1;
    for (int i = 0; i < 16; i++) begin
      check("pop_byte", 32'(rd_data), 32'h41 + i);
      tick();
    end
    check("drained", 32'(rd_valid), 32'd0);
    rd_ready = 0;
    bus(BASE + 32'h8, 1, 32'h10, r);
    bus(BASE + 32'h8, 0, 0, r);
    check("ovf_clear", r, 32'h0000_0008);

    // Push while full with simultaneous pop
    for (int i = 0; i < 16; i++) bus(BASE + 32'h4, 1, 32'h60 + i, r);
    cyc = 1; stb = 1; we = 1; adr = BASE + 32'h4; wdat = 32'h99; sel = 4'h1; rd_ready = 1;
    tick();
    cyc = 0; stb = 0; we = 0; rd_ready = 0;
    tick();
    bus(BASE + 32'h8, 0, 0, r);
    check("full_pushpop", r, 32'h0000_1004);
    rd_ready = 1;
    for (int i = 0; i < 15; i++) begin
      check("pop_pp", 32'(rd_data), 32'h61 + i);
      tick();
    end
    check("last_byte", 32'(rd_data), 32'h99);
    tick();
    rd_ready = 0;

    // Cycle counter
    do_reset();
    for (int i = 0; i < 20; i++) tick();
    bus(BASE + 32'hC, 0, 0, r);
    check("cycles", r, 32'd20);

`ifdef WB_MAILBOX_TIMEOUT_EN
    do_reset();
    for (int i = 0; i < 110; i++) tick();
    check("timeout_flag", {30'd0, tout, done}, 32'h3);
    bus(BASE + 32'hC, 0, 0, r);
    check("cycles_frozen", r, MAXC);
`endif

    // Async reset during a pending STATUS read
    do_reset();
    bus(BASE + 32'h4, 1, 32'h55, r);
    cyc = 1; stb = 1; we = 0; adr = BASE + 32'h8;
    #2 rst_n = 0;
    #1 model_reset();
    check_all();
    tick(); tick();
    check("rst_no_ack", 32'(ack), 32'd0);
    cyc = 0; stb = 0;
    rst_n = 1;
    tick();
    cyc = 1; stb = 1; we = 1; adr = BASE + 32'h20; wdat = 32'h01; sel = 4'hF;
    tick(); tick();
    check("oow_no_ack", {31'd0, ack}, 32'd0);
    cyc = 0; stb = 0;
    tick();

    // Random traffic
    for (int ep = 0; ep < 6; ep++) begin
      do_reset();
      for (int c = 0; c < 400; c++) begin
        int k;
        cyc = ($urandom_range(0, 9) < 8);
        stb = ($urandom_range(0, 9) < 7);
        we  = $urandom_range(0, 1);
        k = $urandom_range(0, 19);
        if (k == 0) adr = BASE + 32'h10 + ($urandom_range(0, 15) << 2);
        else if (k < 3) adr = BASE;
        else adr = BASE + ($urandom_range(1, 3) << 2) + $urandom_range(0, 3);
        k = $urandom_range(0, 19);
        wdat = $urandom();
        if (k == 0) wdat[7:0] = 8'h01;
        else if (k == 1) wdat[7:0] = 8'hFF;
        sel = ($urandom_range(0, 9) < 8) ? 4'hF : 4'(($urandom_range(0, 7)) << 1);
        rd_ready = ($urandom_range(0, 9) < 3);
        tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_mailbox.md
# wb_mailbox

Wishbone classic slave that gives firmware a hardware end-of-test and console channel. It decodes a 16-byte register window on the SoC data bus. Pass (0x01) and fail (0xFF) codes written to CTRL latch sticky done/pass flags, and bytes written to TXDATA are buffered in a FIFO for a downstream consumer (simulation host or UART). It sits beside the SRAM as a bus target and replaces external snooping of raw bus writes.

## Interface
- BASE_ADDR, 32'h8000_0000, window base; bits [3:0] must be zero
- FIFO_DEPTH, 16, TX FIFO entries; power of two, ≥2
- MAX_CYCLES, 200_000, timeout threshold (used only with timeout feature)
- clk  in  1  sole clock
- rst_n  in  1  asynchronous active-low reset
- wb_cyc_i / wb_stb_i / wb_we_i  in  1 each  Wishbone classic controls
- wb_adr_i  in  32  byte address
- wb_dat_i  in  32  write data
- wb_sel_i  in  4  byte enables; byte 0 must be set for CTRL/TXDATA writes to act
- wb_ack_o  out  1  transfer acknowledge
- wb_dat_o  out  32  read data, valid with ack
- done_o  out  1  test finished (pass, fail or timeout), sticky
- pass_o  out  1  finished with pass code, sticky
- timeout_o  out  1  finished by timeout, sticky
- rd_valid_o  out  1  FIFO non-empty
- rd_data_o  out  8  FIFO head byte
- rd_ready_i  in  1  consumer pops when rd_valid_o & rd_ready_i

## Operation
- Select: cyc & stb & (adr[31:4] == BASE_ADDR[31:4]). Unselected cycles get no ack.
- Register map by adr[3:2]:
  - 0x0 CTRL, W: byte0 0x01 gives pass; byte0 0xFF gives fail; other values ignored. Reads 0.
  - 0x4 TXDATA, W: pushes byte0; when full the byte is dropped and overflow is set (sticky). Reads 0.
  - 0x8 STATUS, R: [0] done, [1] pass, [2] full, [3] empty, [4] overflow, [5] timeout, [15:8] FIFO count, rest 0. Writing 1 to bit4 clears overflow.
  - 0xC CYCLES, R: 32-bit cycle counter. Counts every clock in RUN, saturates at 2^32-1, freezes once done.
- FSM states: RUN, DONE_PASS, DONE_FAIL, TIMEOUT.
  - RUN to DONE_PASS on a pass code; RUN to DONE_FAIL on a fail code.
  - All DONE states are terminal until reset. Later CTRL writes are acked and ignored.
- TXDATA writes keep working after done.
- FIFO edge cases:
  - Push and pop in the same cycle while full: push is accepted and count is unchanged.
  - While empty, rd_valid_o is 0, so no pop happens and the push lands.
  - Pop when empty is impossible by construction.

## Timing
- wb_ack_o is registered. It rises one cycle after select, is high for exactly one cycle, and is forced low the following cycle, so max throughput is 1 transfer per 2 cycles.
- If cyc or stb drops before ack, no ack is issued.
- Write side effects (FSM, FIFO push, overflow) commit on the edge that raises ack. Flags are visible the cycle ack is high.
- wb_dat_o is registered alongside ack and is 0 when ack is low.
- rd_data_o is valid combinationally from FIFO head while rd_valid_o=1. A pushed byte appears on rd_valid_o the cycle after the push commits.
- Reset (async, any time, including mid-transfer) sets:
  - wb_ack_o=0, wb_dat_o=0
  - done_o=0, pass_o=0, timeout_o=0, rd_valid_o=0, rd_data_o=0
  - FIFO empty, overflow=0, counter=0, state=RUN
- An in-flight transfer is dropped; the master must retry.

## Configuration
- Macro: WB_MAILBOX_TIMEOUT_EN.
- Defined:
  - In RUN, when the counter reaches MAX_CYCLES the FSM enters TIMEOUT and sets done_o=1, timeout_o=1, pass_o=0.
  - A CTRL pass/fail write committing on the same edge wins over timeout.
- Undefined: there is no TIMEOUT state, timeout_o is tied 0, and STATUS[5] reads 0. The counter is still present.

## Structure
- Package wb_mailbox_pkg holds:
  - register offsets (CTRL/TXDATA/STATUS/CYCLES)
  - STATUS bit indices
  - PASS_CODE=8'h01, FAIL_CODE=8'hFF
  - state enum typedef
- One sub-module, sync_fifo (parameters WIDTH, DEPTH): push/pop/full/empty/count, async active-low reset.

## Test plan
- Reset, then write 0x01 to BASE+0x0 → ack 1 cycle after stb; done_o=1, pass_o=1; STATUS read = 0x0000_000B.
- Write 0xFF to CTRL, then 0x01 → done_o=1, pass_o=0 stays; second write acked, no effect.
- 17 TXDATA writes (0x41..0x51) with rd_ready_i=0 → STATUS count=16, full=1, overflow=1; pop all, bytes 0x41..0x50 in order; write 0x10 to STATUS clears overflow.
- Fill FIFO, then a TXDATA write with rd_ready_i=1 on its commit edge → count stays 16, no overflow, new byte last.
- With WB_MAILBOX_TIMEOUT_EN and MAX_CYCLES=100, no writes → timeout_o=done_o=1 after 100 cycles; CYCLES reads 100 and stays frozen.
- Assert rst_n low during a pending STATUS read → ack never rises; all outputs at reset values; access to BASE+0x20 → no ack.
